// File: rtl/ct_spsram_init_wrap.sv
// Single-port SRAM wrapper: byte/group-masked writes, 1- or 2-cycle registered reads,
// and an optional full-array clear sequencer enabled by CT_SPSRAM_INIT_CLEAR_EN.
module ct_spsram_init_wrap #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 44,
  parameter int WE_WIDTH   = 44,
  parameter int OUT_REG    = 0
) (
  input  logic                  CLK,
  input  logic                  cpurst_b,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  INIT_REQ,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VLD,
  output logic                  INIT_BUSY
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int GW    = DATA_WIDTH / WE_WIDTH;

  if (DATA_WIDTH % WE_WIDTH != 0) begin : g_bad_we_width
    $error("DATA_WIDTH must be an integer multiple of WE_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  req_drop;
  logic                  acc;
  logic                  wr_acc;
  logic                  rd_acc;

`ifdef CT_SPSRAM_INIT_CLEAR_EN
  // state | meaning
  // IDLE  | normal accesses accepted; INIT_REQ starts a clear
  // CLEAR | writes zero at cnt each cycle, accesses dropped
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (INIT_REQ) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (cnt == '1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;
  assign req_drop = (state == IDLE) && INIT_REQ;
`else
  logic unused_init_req;

  assign unused_init_req = INIT_REQ;
  assign busy            = 1'b0;
  assign clr_we          = 1'b0;
  assign clr_addr        = '0;
  assign req_drop        = 1'b0;
`endif

  assign INIT_BUSY = busy;
  assign acc       = !CEN && !busy && !req_drop;
  assign wr_acc    = acc && !GWEN;
  assign rd_acc    = acc && GWEN;

  // Array is intentionally not reset; only the clear sequencer zeroes it.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int g = 0; g < WE_WIDTH; g++) begin
        if (!WEN[g]) mem[A][g*GW +: GW] <= D[g*GW +: GW];
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_vld;

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_q   <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rd_acc;
      if (rd_acc) rd_q <= mem[A];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] q_r;
    logic                  vld_r;

    always_ff @(posedge CLK or negedge cpurst_b) begin
      if (!cpurst_b) begin
        q_r   <= '0;
        vld_r <= 1'b0;
      end else begin
        vld_r <= rd_vld;
        if (rd_vld) q_r <= rd_q;
      end
    end

    assign Q     = q_r;
    assign Q_VLD = vld_r;
  end else begin : g_no_out_reg
    assign Q     = rd_q;
    assign Q_VLD = rd_vld;
  end

endmodule

// File: tb/tb_ct_spsram_init_wrap.sv
// Directed bench for ct_spsram_init_wrap: dut0 (WE_WIDTH=2, OUT_REG=0) and dut1
// (WE_WIDTH=44, OUT_REG=1) share stimulus; clear tests run when CT_SPSRAM_INIT_CLEAR_EN is set.
module tb_ct_spsram_init_wrap;

  logic        CLK;
  logic        cpurst_b;
  logic        cen;
  logic        gwen;
  logic [1:0]  wen0;
  logic [43:0] wen1;
  logic [8:0]  addr;
  logic [43:0] din;
  logic        init_req;
  logic [43:0] q0, q1;
  logic        vld0, vld1;
  logic        busy0, busy1;

  int n_vec = 0;
  int n_err = 0;

  ct_spsram_init_wrap #(.ADDR_WIDTH(9), .DATA_WIDTH(44), .WE_WIDTH(2), .OUT_REG(0)) dut0 (
    .CLK(CLK), .cpurst_b(cpurst_b), .CEN(cen), .GWEN(gwen), .WEN(wen0), .A(addr),
    .D(din), .INIT_REQ(init_req), .Q(q0), .Q_VLD(vld0), .INIT_BUSY(busy0));

  ct_spsram_init_wrap #(.ADDR_WIDTH(9), .DATA_WIDTH(44), .WE_WIDTH(44), .OUT_REG(1)) dut1 (
    .CLK(CLK), .cpurst_b(cpurst_b), .CEN(cen), .GWEN(gwen), .WEN(wen1), .A(addr),
    .D(din), .INIT_REQ(init_req), .Q(q1), .Q_VLD(vld1), .INIT_BUSY(busy1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        cen;
    logic        gwen;
    logic [1:0]  wen;
    logic [8:0]  a;
    logic [43:0] d;
    logic        vld;
    logic [43:0] q;
  } vec_t;

  vec_t tv [20];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic c, input logic g, input logic [1:0] w,
                       input logic [8:0] a, input logic [43:0] d, input logic ir);
    cen      = c;
    gwen     = g;
    wen0     = w;
    wen1     = {{22{w[1]}}, {22{w[0]}}};
    addr     = a;
    din      = d;
    init_req = ir;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 2'b11, 9'h000, 44'h0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [43:0] act, input logic [43:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

`ifdef CT_SPSRAM_INIT_CLEAR_EN
  // Counts cycles with INIT_BUSY high; optionally injects a re-request and a write mid-clear.
  task automatic wait_clear(input int pulse_at, input int wr_at, output int n);
    n = 0;
    while (busy0 && n < 2000) begin
      n++;
      if (n == pulse_at) drive(1'b1, 1'b1, 2'b11, 9'h000, 44'h0, 1'b1);
      else if (n == wr_at) drive(1'b0, 1'b0, 2'b00, 9'h020, 44'h777, 1'b0);
      else idle();
      tick();
    end
    idle();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic        prev_vld;
    logic [43:0] prev_q;
    logic        exp_busy;
    int          nb;

`ifdef CT_SPSRAM_INIT_CLEAR_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif

    tv[0]  = '{1'b0, 1'b0, 2'b00, 9'h055, 44'hFFF_FFFF_FFFF, 1'b0, 44'h0};
    tv[1]  = '{1'b0, 1'b0, 2'b10, 9'h055, 44'h000_0000_0000, 1'b0, 44'h0};
    tv[2]  = '{1'b0, 1'b1, 2'b11, 9'h055, 44'h0,             1'b1, 44'hFFF_FFC0_0000};
    tv[3]  = '{1'b1, 1'b1, 2'b11, 9'h000, 44'h0,             1'b0, 44'hFFF_FFC0_0000};
    tv[4]  = '{1'b0, 1'b0, 2'b00, 9'h007, 44'h123,           1'b0, 44'hFFF_FFC0_0000};
    tv[5]  = '{1'b0, 1'b1, 2'b11, 9'h007, 44'h0,             1'b1, 44'h123};
    tv[6]  = '{1'b0, 1'b0, 2'b00, 9'h007, 44'hABC,           1'b0, 44'h123};
    tv[7]  = '{1'b0, 1'b1, 2'b11, 9'h007, 44'h0,             1'b1, 44'hABC};
    tv[8]  = '{1'b0, 1'b0, 2'b11, 9'h007, 44'h0,             1'b0, 44'hABC};
    tv[9]  = '{1'b0, 1'b1, 2'b11, 9'h007, 44'h0,             1'b1, 44'hABC};
    tv[10] = '{1'b0, 1'b0, 2'b01, 9'h007, 44'hFFF_FFFF_FFFF, 1'b0, 44'hABC};
    tv[11] = '{1'b0, 1'b1, 2'b11, 9'h055, 44'h0,             1'b1, 44'hFFF_FFC0_0000};
    tv[12] = '{1'b0, 1'b1, 2'b11, 9'h007, 44'h0,             1'b1, 44'hFFF_FFC0_0ABC};
    tv[13] = '{1'b1, 1'b0, 2'b00, 9'h007, 44'h555,           1'b0, 44'hFFF_FFC0_0ABC};
    tv[14] = '{1'b0, 1'b1, 2'b11, 9'h007, 44'h0,             1'b1, 44'hFFF_FFC0_0ABC};
    tv[15] = '{1'b0, 1'b0, 2'b00, 9'h1FF, 44'h2AA_AAAA_AAAA, 1'b0, 44'hFFF_FFC0_0ABC};
    tv[16] = '{1'b0, 1'b0, 2'b00, 9'h000, 44'h155_5555_5555, 1'b0, 44'hFFF_FFC0_0ABC};
    tv[17] = '{1'b0, 1'b1, 2'b11, 9'h1FF, 44'h0,             1'b1, 44'h2AA_AAAA_AAAA};
    tv[18] = '{1'b0, 1'b1, 2'b11, 9'h000, 44'h0,             1'b1, 44'h155_5555_5555};
    tv[19] = '{1'b1, 1'b1, 2'b11, 9'h000, 44'h0,             1'b0, 44'h155_5555_5555};

    cpurst_b = 1'b0;
    idle();
    repeat (3) tick();
    chk("rst_q0", q0, 44'h0);
    chk("rst_vld0", {43'h0, vld0}, 44'h0);
    chk("rst_q1", q1, 44'h0);
    chk("rst_vld1", {43'h0, vld1}, 44'h0);
    chk("rst_busy0", {43'h0, busy0}, {43'h0, exp_busy});
    chk("rst_busy1", {43'h0, busy1}, {43'h0, exp_busy});
    cpurst_b = 1'b1;

`ifdef CT_SPSRAM_INIT_CLEAR_EN
    wait_clear(-1, -1, nb);
    chk("clr_len_por", 44'(nb), 44'd512);
    chk("clr_busy1_done", {43'h0, busy1}, 44'h0);
    drive(1'b0, 1'b1, 2'b11, 9'h000, 44'h0, 1'b0);
    tick();
    chk("clr_rd000_vld", {43'h0, vld0}, 44'h1);
    chk("clr_rd000_q", q0, 44'h0);
    drive(1'b0, 1'b1, 2'b11, 9'h1FF, 44'h0, 1'b0);
    tick();
    chk("clr_rd1ff_vld", {43'h0, vld0}, 44'h1);
    chk("clr_rd1ff_q", q0, 44'h0);
    idle();
    tick();
    tick();
`else
    tick();
    chk("noclr_busy", {43'h0, busy0}, 44'h0);
`endif

    prev_vld = 1'b0;
    prev_q   = 44'h0;
    for (int i = 0; i < 20; i++) begin
      drive(tv[i].cen, tv[i].gwen, tv[i].wen, tv[i].a, tv[i].d, 1'b0);
      tick();
      chk($sformatf("v%0d_q0", i), q0, tv[i].q);
      chk($sformatf("v%0d_vld0", i), {43'h0, vld0}, {43'h0, tv[i].vld});
      chk($sformatf("v%0d_q1", i), q1, prev_q);
      chk($sformatf("v%0d_vld1", i), {43'h0, vld1}, {43'h0, prev_vld});
      prev_vld = tv[i].vld;
      prev_q   = tv[i].q;
    end

    // Back-to-back reads through the two-stage output path.
    drive(1'b0, 1'b0, 2'b00, 9'h001, 44'h11, 1'b0); tick();
    drive(1'b0, 1'b0, 2'b00, 9'h002, 44'h22, 1'b0); tick();
    drive(1'b0, 1'b0, 2'b00, 9'h003, 44'h33, 1'b0); tick();
    drive(1'b0, 1'b1, 2'b11, 9'h001, 44'h0, 1'b0);  tick();
    chk("or_c1_vld1", {43'h0, vld1}, 44'h0);
    chk("or_c1_q0", q0, 44'h11);
    drive(1'b0, 1'b1, 2'b11, 9'h002, 44'h0, 1'b0);  tick();
    chk("or_c2_q1", q1, 44'h11);
    chk("or_c2_vld1", {43'h0, vld1}, 44'h1);
    drive(1'b0, 1'b1, 2'b11, 9'h003, 44'h0, 1'b0);  tick();
    chk("or_c3_q1", q1, 44'h22);
    chk("or_c3_vld1", {43'h0, vld1}, 44'h1);
    idle(); tick();
    chk("or_c4_q1", q1, 44'h33);
    chk("or_c4_vld1", {43'h0, vld1}, 44'h1);
    chk("or_c4_vld0", {43'h0, vld0}, 44'h0);
    tick();
    chk("or_c5_vld1", {43'h0, vld1}, 44'h0);
    chk("or_c5_q1_hold", q1, 44'h33);

`ifdef CT_SPSRAM_INIT_CLEAR_EN
    // Read before clear completes with old data; write alongside INIT_REQ is dropped.
    drive(1'b0, 1'b0, 2'b00, 9'h010, 44'h5A5, 1'b0); tick();
    drive(1'b0, 1'b1, 2'b11, 9'h010, 44'h0, 1'b0);   tick();
    chk("pre_clr_q0", q0, 44'h5A5);
    drive(1'b0, 1'b0, 2'b00, 9'h010, 44'h0AB, 1'b1); tick();
    chk("ireq_busy_next", {43'h0, busy0}, 44'h1);
    chk("ireq_vld0", {43'h0, vld0}, 44'h0);
    chk("pre_clr_q1", q1, 44'h5A5);
    chk("pre_clr_vld1", {43'h0, vld1}, 44'h1);
    wait_clear(100, 60, nb);
    chk("clr_len_ireq", 44'(nb), 44'd512);
    drive(1'b0, 1'b1, 2'b11, 9'h010, 44'h0, 1'b0); tick();
    chk("clr_rd010_q", q0, 44'h0);
    chk("clr_rd010_vld", {43'h0, vld0}, 44'h1);
    drive(1'b0, 1'b1, 2'b11, 9'h020, 44'h0, 1'b0); tick();
    chk("clr_wr_dropped", q0, 44'h0);

    // Reset in the middle of a clear restarts it from address 0.
    drive(1'b0, 1'b0, 2'b00, 9'h030, 44'h3C3, 1'b0); tick();
    drive(1'b0, 1'b1, 2'b11, 9'h030, 44'h0, 1'b0);   tick();
    chk("mid_pre_q0", q0, 44'h3C3);
    drive(1'b1, 1'b1, 2'b11, 9'h000, 44'h0, 1'b1);   tick();
    idle();
    repeat (256) tick();
    chk("mid_busy", {43'h0, busy0}, 44'h1);
    #2;
    cpurst_b = 1'b0;
    #1;
    chk("mid_rst_q0", q0, 44'h0);
    chk("mid_rst_vld0", {43'h0, vld0}, 44'h0);
    chk("mid_rst_q1", q1, 44'h0);
    chk("mid_rst_busy", {43'h0, busy0}, 44'h1);
    tick();
    cpurst_b = 1'b1;
    wait_clear(-1, -1, nb);
    chk("clr_len_rst", 44'(nb), 44'd512);
`else
    // INIT_REQ has no effect when the clear sequencer is not built.
    drive(1'b0, 1'b0, 2'b00, 9'h010, 44'h0AB, 1'b1); tick();
    chk("noclr_ireq_busy", {43'h0, busy0}, 44'h0);
    drive(1'b0, 1'b1, 2'b11, 9'h010, 44'h0, 1'b0);   tick();
    chk("noclr_ireq_q0", q0, 44'h0AB);
    chk("noclr_ireq_vld0", {43'h0, vld0}, 44'h1);
    idle(); tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ct_spsram_init_wrap.md
CT_SPSRAM_INIT_WRAP -- requirements
Module: ct_spsram_init_wrap

Interface
REQ-001 SHALL: parameter ADDR_WIDTH, default 9, word address width; depth = 2^ADDR_WIDTH.
REQ-002 SHALL: parameter DATA_WIDTH, default 44, word width in bits.
REQ-003 SHALL: parameter WE_WIDTH, default 44, write-enable groups; group width = DATA_WIDTH/WE_WIDTH; non-integer ratio rejected at elaboration.
REQ-004 SHALL: parameter OUT_REG, default 0; 1 adds one output register stage.
REQ-005 SHALL: CLK  input  1  single clock, all logic on rising edge.
REQ-006 SHALL: cpurst_b  input  1  asynchronous active-low reset.
REQ-007 SHALL: CEN  input  1  active-low access enable.
REQ-008 SHALL: GWEN  input  1  active-low global write enable; high = read.
REQ-009 SHALL: WEN  input  WE_WIDTH  active-low per-group write enable.
REQ-010 SHALL: A  input  ADDR_WIDTH  word address.
REQ-011 SHALL: D  input  DATA_WIDTH  write data.
REQ-012 SHALL: INIT_REQ  input  1  pulse requesting full-array clear.
REQ-013 SHALL: Q  output  DATA_WIDTH  read data.
REQ-014 SHALL: Q_VLD  output  1  one-cycle strobe, Q carries new read data.
REQ-015 SHALL: INIT_BUSY  output  1  high while clear sequence runs; accesses dropped.

Function
REQ-016 SHALL: accepted access = CEN low and INIT_BUSY low in the same cycle.
REQ-017 SHALL: accepted write (GWEN low) updates only groups g with WEN[g] low at A; other groups and addresses unchanged.
REQ-018 SHALL: accepted read (GWEN high) drives Q and Q_VLD high 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
REQ-019 SHALL: Q holds last read value when no read completes; writes never alter Q (no write-through).
REQ-020 SHALL: back-to-back reads every cycle; full throughput, Q_VLD continuous.
REQ-021 SHALL: read to address written in previous cycle returns new data.
REQ-022 SHALL: clear FSM states IDLE, CLEAR; IDLE->CLEAR on reset release or INIT_REQ high in IDLE; CLEAR writes all-zero to address counter, counter +1 per cycle; CLEAR->IDLE after address 2^ADDR_WIDTH-1 written.
REQ-023 SHALL: clear takes exactly 2^ADDR_WIDTH cycles; INIT_BUSY high in CLEAR only, low first cycle of IDLE.
REQ-024 SHALL: INIT_REQ in same cycle as CEN low in IDLE: access dropped, clear starts next cycle.
REQ-025 SHALL: INIT_REQ during CLEAR ignored; counter not restarted.
REQ-026 SHALL: reads accepted before CLEAR entry still complete with pre-clear data and Q_VLD.
REQ-027 SHALL: counter width ADDR_WIDTH; terminal detection on all-ones, no wrap beyond.

Reset
REQ-028 SHALL: cpurst_b low: Q=0, Q_VLD=0, output stage=0, counter=0, FSM=CLEAR (with macro) else IDLE, INIT_BUSY=1 with macro else 0.
REQ-029 SHALL: array contents not reset; reset asserted mid-clear restarts clear at address 0 after release.

Configuration
REQ-030 SHALL: macro CT_SPSRAM_INIT_CLEAR_EN defined: FSM, counter, INIT_REQ behaviour as REQ-022..027.
REQ-031 SHALL: macro undefined: no FSM/counter, INIT_BUSY tied 0, INIT_REQ ignored, array uninitialised after reset.

Verification
REQ-032 SHALL: macro on, release reset, hold CEN high -> INIT_BUSY high exactly 512 cycles; then reads of 0x000, 0x1FF return 0, Q_VLD 1 cycle later.
REQ-033 SHALL: WE_WIDTH=2, write 0xFFF_FFFF_FFFF to 0x055 WEN=2'b00, then write 0x000_0000_0000 WEN=2'b10 -> read 0x055 returns 0xFFF_FFC0_0000.
REQ-034 SHALL: OUT_REG=1, reads 0x001,0x002,0x003 consecutive cycles after writing 0x11,0x22,0x33 -> Q=0x11,0x22,0x33 cycles 2,3,4, Q_VLD high 3 cycles.
REQ-035 SHALL: INIT_REQ with write 0x0AB to 0x010 same cycle -> write dropped, INIT_BUSY next cycle, later read 0x010 = 0.
REQ-036 SHALL: cpurst_b low at clear address 0x100 -> outputs per REQ-028; after release clear restarts at 0, INIT_BUSY 512 cycles.
REQ-037 SHALL: macro off, release reset -> INIT_BUSY 0; write 0x123 to 0x007 cycle 1, read cycle 2 -> Q=0x123, Q_VLD cycle 3.
